uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of the UART receiver. Captures each byte pulsed on RX_DATA_RDY together with its
//  parity/framing error tags. Buffers them in a first-word-fall-through (FWFT) FIFO for a slower consumer (command
//  parser / CPU bus). Reports occupancy and holds a sticky overflow flag.
// PARAMETERS
//  DEPTH_LOG2  4  log2 of FIFO depth (default 16 entries of 10 bits: {FERR,PERR,DATA[7:0]})
//  DROP_ERR    0  1 = discard bytes flagged PARITY_ERR or FRM_ERR instead of storing them
// PORTS
//  CLK          in   1             system clock; single clock domain, all logic on rising edge
//  RST          in   1             asynchronous, active-high reset
//  RX_DATA      in   8             received byte from UART receiver, valid when RX_DATA_RDY=1
//  RX_DATA_RDY  in   1             one-cycle strobe: RX_DATA and error flags valid
//  PARITY_ERR   in   1             parity error for the strobed byte
//  FRM_ERR      in   1             framing (stop-bit) error for the strobed byte
//  RD_EN        in   1             consumer pop request; honoured only when EMPTY=0
//  DOUT         out  8             oldest stored byte (FWFT); valid when EMPTY=0
//  DOUT_PERR    out  1             parity-error tag of DOUT
//  DOUT_FERR    out  1             framing-error tag of DOUT
//  EMPTY        out  1             no entries stored
//  FULL         out  1             COUNT == 2**DEPTH_LOG2
//  COUNT        out  DEPTH_LOG2+1  number of stored entries
//  OVERFLOW     out  1             sticky: a byte was lost because the FIFO was full
//  OVF_CLR      in   1             one-cycle pulse, clears OVERFLOW
// BEHAVIOUR
//  Reset: pointers=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, DOUT/DOUT_PERR/DOUT_FERR=0. Reset may assert mid-stream;
//   all contents are discarded, no partial state is retained.
//  Write: wr = RX_DATA_RDY & ~(DROP_ERR & (PARITY_ERR|FRM_ERR)) & (~FULL | rd). Stores {FRM_ERR,PARITY_ERR,RX_DATA}
//   at the write pointer.
//  Read: rd = RD_EN & ~EMPTY. RD_EN while EMPTY is ignored; no error is flagged.
//  FWFT latency: a byte strobed in cycle N into an empty FIFO appears on DOUT with EMPTY=0 in cycle N+1. After a pop in
//   cycle N, the next entry (or EMPTY=1) is presented in cycle N+1.
//  DOUT holds the last-read value while EMPTY=1; it is don't-care to the consumer.
//  Pointers are DEPTH_LOG2 bits and wrap modulo depth with no special case. COUNT is updated as
//   COUNT + wr - rd, saturating by construction at 0 and depth.
//  Simultaneous wr & rd: both take effect and COUNT is unchanged. This applies when FULL: the pop frees the slot and
//   the new byte is accepted. This applies when EMPTY: rd=0, so the write is accepted and COUNT becomes 1.
//  Overflow: RX_DATA_RDY & FULL & ~rd (and not dropped) sets OVERFLOW. The byte is lost; stored contents and
//   pointers are unchanged. If set and OVF_CLR occur in the same cycle, set wins.
//  A byte dropped by DROP_ERR=1 does not affect COUNT or OVERFLOW.
//  Flags EMPTY, FULL and COUNT are registered and change in the cycle after the causing edge together with DOUT.
// STRUCTURE
//  Shared package uart_pkg: UART_DATA_W=8, RX_ENTRY_W=10, and field index constants RX_ENTRY_PERR=8, RX_ENTRY_FERR=9.
//   The receiver, transmitter and this FIFO all use these.
//  One sub-module uart_fifo_mem: simple dual-port memory (1 write, 1 read port) with sync write and async read,
//   parameterised by width and depth. The pointer/flag control and the FWFT output register stay in uart_rx_fifo.
// TESTING
//  1. Reset, strobe 0x41, 0x42, 0x43 with no errors -> DOUT=0x41 one cycle after the first strobe, COUNT=3.
//     Then three RD_EN pops -> 0x41,0x42,0x43 in order, EMPTY=1.
//  2. Strobe 16 bytes 0x00..0x0F (DEPTH_LOG2=4) -> FULL=1, COUNT=16.
//     Then strobe 0xAA -> OVERFLOW=1, DOUT still 0x00, COUNT=16. Then OVF_CLR -> OVERFLOW=0.
//  3. FULL plus same-cycle RD_EN and strobe 0x55 -> 0x00 popped, 0x55 stored last, COUNT=16, OVERFLOW stays 0.
//  4. Strobe 0x7E with PARITY_ERR=1, then 0x7F with FRM_ERR=1 -> DOUT_PERR=1 for 0x7E, DOUT_FERR=1 for 0x7F.
//     With DROP_ERR=1, both are dropped and EMPTY stays 1.
//  5. RD_EN held high while EMPTY, then a single strobe 0x12 -> no underflow, COUNT=1 then 0, 0x12 seen once.
//     Also check 40 write/read cycles for pointer wrap correctness.
//  6. Assert RST asynchronously (mid-cycle) with COUNT=5 -> all outputs return to reset values immediately.
//     After release, the next strobe 0x99 reads back first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the transmitter and the RX buffer.
// Entry layout is {ferr, perr, data}.
package uart_pkg;
  localparam int unsigned UART_DATA_W   = 8;
  localparam int unsigned RX_ENTRY_W    = 10;
  localparam int unsigned RX_ENTRY_PERR = 8;
  localparam int unsigned RX_ENTRY_FERR = 9;

  typedef struct packed {
    logic                   ferr;
    logic                   perr;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

  function automatic rx_entry_t make_entry(input logic [UART_DATA_W-1:0] data,
                                           input logic perr, input logic ferr);
    rx_entry_t e;
    e.ferr = ferr;
    e.perr = perr;
    e.data = data;
    return e;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-capture and consumer signals of the UART receive buffer.
// The master side is the receiver/consumer pair; the slave side is the buffer.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_data_rdy;
  logic                   parity_err;
  logic                   frm_err;
  logic                   rd_en;
  logic                   ovf_clr;
  logic [UART_DATA_W-1:0] dout;
  logic                   dout_perr;
  logic                   dout_ferr;
  logic                   empty;
  logic                   full;
  logic [DEPTH_LOG2:0]    count;
  logic                   overflow;

  modport master (
    output rx_data, rx_data_rdy, parity_err, frm_err, rd_en, ovf_clr,
    input  dout, dout_perr, dout_ferr, empty, full, count, overflow
  );

  modport slave (
    input  rx_data, rx_data_rdy, parity_err, frm_err, rd_en, ovf_clr,
    output dout, dout_perr, dout_ferr, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module uart_fifo_mem #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata_c
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive buffer behind the UART receiver: stores bytes with their error tags,
// reports occupancy and keeps a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter bit          DROP_ERR   = 1'b0
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned     CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]      count_q, count_nxt;
  logic                  empty_q, full_q, overflow_q;
  logic [RX_ENTRY_W-1:0] head_q, head_nxt, wdata, mem_rdata;
  logic                  drop, wr, rd, ovf_set;

  // Accept/pop decisions and next head; a write into an empty slot bypasses the memory.
  always_comb begin
    drop       = DROP_ERR && (bus.parity_err || bus.frm_err);
    rd         = bus.rd_en && !empty_q;
    wr         = bus.rx_data_rdy && !drop && (!full_q || rd);
    ovf_set    = bus.rx_data_rdy && !drop && full_q && !rd;
    wdata      = RX_ENTRY_W'(make_entry(bus.rx_data, bus.parity_err, bus.frm_err));
    rd_ptr_nxt = rd ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
    count_nxt  = count_q + CNT_W'(wr) - CNT_W'(rd);
    head_nxt   = (wr && (rd_ptr_nxt == wr_ptr)) ? wdata : mem_rdata;
  end

  uart_fifo_mem #(
    .WIDTH  (RX_ENTRY_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .we      (wr),
    .waddr   (wr_ptr),
    .wdata   (wdata),
    .raddr   (rd_ptr_nxt),
    .rdata_c (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      rd_ptr     <= rd_ptr_nxt;
      count_q    <= count_nxt;
      empty_q    <= (count_nxt == '0);
      full_q     <= (count_nxt == DEPTH);
      overflow_q <= ovf_set || (overflow_q && !bus.ovf_clr);
      // Head keeps the last-read entry while the buffer is empty.
      if (count_nxt != '0) head_q <= head_nxt;
    end
  end

  assign bus.dout      = head_q[UART_DATA_W-1:0];
  assign bus.dout_perr = head_q[RX_ENTRY_PERR];
  assign bus.dout_ferr = head_q[RX_ENTRY_FERR];
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: one keep-errors and one drop-errors instance share stimulus,
// each checked against a queue model of the buffer.
module tb_uart_rx_fifo;
  localparam int unsigned DL2 = 4;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus0 ();
  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus1 ();

  assign bus1.rx_data     = bus0.rx_data;
  assign bus1.rx_data_rdy = bus0.rx_data_rdy;
  assign bus1.parity_err  = bus0.parity_err;
  assign bus1.frm_err     = bus0.frm_err;
  assign bus1.rd_en       = bus0.rd_en;
  assign bus1.ovf_clr     = bus0.ovf_clr;

  uart_rx_fifo #(.DEPTH_LOG2(DL2), .DROP_ERR(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_rx_fifo #(.DEPTH_LOG2(DL2), .DROP_ERR(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Reference model: expected contents of each buffer, oldest first.
  logic [9:0] mq [2][$];
  logic       movf [2];

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t act=0x%0h exp=0x%0h", name, i, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        movf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit dropped, popped, lost;
        dropped = (i == 1) && (bus0.parity_err || bus0.frm_err);
        popped  = bus0.rd_en && (mq[i].size() != 0);
        lost    = 1'b0;
        if (popped) void'(mq[i].pop_front());
        if (bus0.rx_data_rdy && !dropped) begin
          if (mq[i].size() < DEPTH) mq[i].push_back({bus0.frm_err, bus0.parity_err, bus0.rx_data});
          else lost = 1'b1;
        end
        if (lost) movf[i] = 1'b1;
        else if (bus0.ovf_clr) movf[i] = 1'b0;
      end
    end
  end

  // Monitor: compare flags every cycle, and the head entry whenever data is presented.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        logic [4:0] a_cnt;
        logic       a_empty, a_full, a_ovf;
        logic [9:0] a_head;
        a_cnt   = (i == 0) ? bus0.count : bus1.count;
        a_empty = (i == 0) ? bus0.empty : bus1.empty;
        a_full  = (i == 0) ? bus0.full : bus1.full;
        a_ovf   = (i == 0) ? bus0.overflow : bus1.overflow;
        a_head  = (i == 0) ? {bus0.dout_ferr, bus0.dout_perr, bus0.dout}
                           : {bus1.dout_ferr, bus1.dout_perr, bus1.dout};
        check("count", i, 32'(a_cnt), 32'(mq[i].size()));
        check("empty", i, 32'(a_empty), 32'(mq[i].size() == 0));
        check("full", i, 32'(a_full), 32'(mq[i].size() == DEPTH));
        check("overflow", i, 32'(a_ovf), 32'(movf[i]));
        if (mq[i].size() != 0) check("head", i, 32'(a_head), 32'(mq[i][0]));
      end
    end
  end

  task automatic cyc(input logic rdy, input logic [7:0] d, input logic pe, input logic fe,
                     input logic rd, input logic clr);
    bus0.rx_data_rdy = rdy;
    bus0.rx_data     = d;
    bus0.parity_err  = pe;
    bus0.frm_err     = fe;
    bus0.rd_en       = rd;
    bus0.ovf_clr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_dout"}, 0, 32'(bus0.dout), 32'h0);
    check({name, "_perr"}, 0, 32'(bus0.dout_perr), 32'h0);
    check({name, "_ferr"}, 0, 32'(bus0.dout_ferr), 32'h0);
    check({name, "_count"}, 0, 32'(bus0.count), 32'h0);
    check({name, "_empty"}, 0, 32'(bus0.empty), 32'h1);
    check({name, "_full"}, 0, 32'(bus0.full), 32'h0);
    check({name, "_ovf"}, 0, 32'(bus0.overflow), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus0.rx_data_rdy = 1'b0;
    bus0.rx_data     = 8'h00;
    bus0.parity_err  = 1'b0;
    bus0.frm_err     = 1'b0;
    bus0.rd_en       = 1'b0;
    bus0.ovf_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    cyc(0, 8'h00, 0, 0, 0, 0);

    // Three bytes in, then three pops.
    cyc(1, 8'h41, 0, 0, 0, 0);
    check("fwft_first", 0, 32'(bus0.dout), 32'h41);
    cyc(1, 8'h42, 0, 0, 0, 0);
    cyc(1, 8'h43, 0, 0, 0, 0);
    check("cnt3", 0, 32'(bus0.count), 32'd3);
    repeat (3) cyc(0, 8'h00, 0, 0, 1, 0);
    check("empty_after_pops", 0, 32'(bus0.empty), 32'h1);

    // Fill, overflow, clear.
    for (int b = 0; b < 16; b++) cyc(1, 8'(b), 0, 0, 0, 0);
    check("full16", 0, 32'(bus0.full), 32'h1);
    cyc(1, 8'hAA, 0, 0, 0, 0);
    check("ovf_set", 0, 32'(bus0.overflow), 32'h1);
    check("ovf_dout", 0, 32'(bus0.dout), 32'h00);
    cyc(0, 8'h00, 0, 0, 0, 1);
    check("ovf_clr", 0, 32'(bus0.overflow), 32'h0);

    // Pop and write while full, then drain.
    cyc(1, 8'h55, 0, 0, 1, 0);
    check("full_rw_cnt", 0, 32'(bus0.count), 32'd16);
    check("full_rw_ovf", 0, 32'(bus0.overflow), 32'h0);
    repeat (16) cyc(0, 8'h00, 0, 0, 1, 0);

    // Error tags; the drop instance discards both bytes.
    cyc(1, 8'h7E, 1, 0, 0, 0);
    cyc(1, 8'h7F, 0, 1, 0, 0);
    check("drop_empty", 1, 32'(bus1.empty), 32'h1);
    check("perr_tag", 0, 32'({bus0.dout_ferr, bus0.dout_perr, bus0.dout}), 32'h17E);
    cyc(0, 8'h00, 0, 0, 1, 0);
    check("ferr_tag", 0, 32'({bus0.dout_ferr, bus0.dout_perr, bus0.dout}), 32'h27F);
    cyc(0, 8'h00, 0, 0, 1, 0);

    // Reads while empty are ignored.
    repeat (3) cyc(0, 8'h00, 0, 0, 1, 0);
    cyc(1, 8'h12, 0, 0, 1, 0);
    check("underflow_cnt1", 0, 32'(bus0.count), 32'd1);
    cyc(0, 8'h00, 0, 0, 1, 0);
    check("underflow_cnt0", 0, 32'(bus0.count), 32'd0);

    // Random traffic: a filling phase then a draining phase, repeated for pointer wrap.
    for (int ph = 0; ph < 6; ph++) begin
      for (int n = 0; n < 50; n++) begin
        int unsigned rdp;
        rdp = (ph % 2 == 0) ? 35 : 75;
        cyc(($urandom_range(99) < 60), 8'($urandom), ($urandom_range(9) == 0),
            ($urandom_range(9) == 0), ($urandom_range(99) < rdp), ($urandom_range(7) == 0));
      end
    end
    repeat (20) cyc(0, 8'h00, 0, 0, 1, 1);

    // Asynchronous reset in the middle of a cycle with five entries stored.
    for (int b = 0; b < 5; b++) cyc(1, 8'(8'hC0 + b), 0, 0, 0, 0);
    check("pre_rst_cnt5", 0, 32'(bus0.count), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 8'h99, 0, 0, 0, 0);
    check("post_rst_first", 0, 32'(bus0.dout), 32'h99);
    cyc(0, 8'h00, 0, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
